// File: rtl/uart_pkg.sv
// Shared types and defaults for the framed UART receiver (uart_rx_frame / uart_rx_RCU).
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 10;
    localparam int DEFAULT_NUM_BYTES    = 36;
    localparam int BITS_PER_BYTE        = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_RCU.sv
// Receive control unit: bit-timing FSM that turns the synchronized line into
// per-bit sample strobes and a byte_done strobe at the stop-bit sample point.
module uart_rx_RCU
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic sin,
    output logic bit_strobe,
    output logic byte_done
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_M1  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_M1   = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(BITS_PER_BYTE - 1);

    rx_state_t       state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic            tick_q, tick_d;
    logic            sin_prev_q;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + TW'(1);
        bit_idx_d = bit_idx_q;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (sin_prev_q && !sin) begin
                    state_d   = START;
                    bit_idx_d = '0;
                end
            end
            START: begin
                if (tick_q) begin
                    timer_d = '0;
                    state_d = sin ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick_q) begin
                    timer_d = '0;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick_q) begin
                    timer_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clear) begin
            state_d   = IDLE;
            timer_d   = '0;
            bit_idx_d = '0;
        end

        // Tick is registered one cycle ahead so it lines up exactly with the sample cycle.
        tick_d = ((state_d == START) && (timer_d == HALF_M1)) ||
                 (((state_d == DATA) || (state_d == STOP)) && (timer_d == BIT_M1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            tick_q     <= 1'b0;
            sin_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            tick_q     <= tick_d;
            sin_prev_q <= sin;
        end
    end

    assign bit_strobe = tick_q && (state_q == DATA);
    assign byte_done  = tick_q && (state_q == STOP);

endmodule

// File: rtl/uart_rx_frame.sv
// Framed UART receiver: assembles NUM_BYTES bytes into rx_data with valid/ack handshake.
// Define UART_RX_FRAMING_CHECK_EN to enable stop-bit checking and framing_error.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int NUM_BYTES    = DEFAULT_NUM_BYTES
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               serial_in,
    input  logic                               clear,
    input  logic                               rx_ack,
    output logic [BITS_PER_BYTE*NUM_BYTES-1:0] rx_data,
    output logic                               rx_valid,
    output logic                               framing_error,
    output logic                               overrun_error
);

    localparam int FRAME_W = BITS_PER_BYTE * NUM_BYTES;
    localparam int CNT_W   = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

    logic                     sync1_q, sync1_d;
    logic                     sync2_q, sync2_d;
    logic                     sin;
    logic [BITS_PER_BYTE-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [FRAME_W-1:0]       buf_q, buf_d;
    logic [FRAME_W-1:0]       rx_data_q, rx_data_d;
    logic                     rx_valid_q, rx_valid_d;
    logic                     overrun_q, overrun_d;
    logic                     bit_strobe;
    logic                     byte_done;
    logic                     accept;
    logic                     frame_done;

    assign sin = sync2_q;

    uart_rx_RCU #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rcu (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .sin        (sin),
        .bit_strobe (bit_strobe),
        .byte_done  (byte_done)
    );

`ifdef UART_RX_FRAMING_CHECK_EN
    logic framing_q, framing_d;
    logic ferr_set;

    // A bad stop bit drops the byte; a coincident clear wins and leaves the flag alone.
    assign accept   = byte_done && sin && !clear;
    assign ferr_set = byte_done && !sin && !clear;
`else
    assign accept   = byte_done && !clear;
`endif

    assign frame_done = accept && (cnt_q == LAST_CNT);

    // First byte of a frame lands in the most significant slot.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_slot
            assign buf_d[gi*BITS_PER_BYTE +: BITS_PER_BYTE] =
                (accept && (cnt_q == CNT_W'(NUM_BYTES - 1 - gi))) ?
                shift_q : buf_q[gi*BITS_PER_BYTE +: BITS_PER_BYTE];
        end
    endgenerate

    always_comb begin
        sync1_d = serial_in;
        sync2_d = sync1_q;
        shift_d = bit_strobe ? {shift_q[BITS_PER_BYTE-2:0], sin} : shift_q;

        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = frame_done ? '0 : cnt_q + CNT_W'(1);
        end
`ifdef UART_RX_FRAMING_CHECK_EN
        else if (ferr_set) begin
            cnt_d = '0;
        end
        framing_d = framing_q | ferr_set;
`endif

        rx_data_d  = frame_done ? buf_d : rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        if (rx_valid_q && rx_ack) begin
            rx_valid_d = 1'b0;
        end
        if (frame_done) begin
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rx_ack) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            shift_q    <= '0;
            cnt_q      <= '0;
            buf_q      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef UART_RX_FRAMING_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            framing_q <= 1'b0;
        end else begin
            framing_q <= framing_d;
        end
    end
    assign framing_error = framing_q;
`else
    assign framing_error = 1'b0;
`endif

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign overrun_error = overrun_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: table of whole-frame vectors plus hand-written corner sequences.
module tb_uart_rx_frame;

    localparam int CPB       = 10;
    localparam int NB        = 36;
    localparam int FW        = 8 * NB;
    localparam int RISE_EXP  = 2 + CPB / 2 + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          serial_in;
    logic          clear;
    logic          rx_ack;
    logic [FW-1:0] rx_data;
    logic          rx_valid;
    logic          framing_error;
    logic          overrun_error;

    int checks   = 0;
    int failures = 0;
    int rise_at  = 0;

    typedef struct {
        logic [7:0] base;
        logic [7:0] step;
        logic       ack_before;
        logic       exp_valid;
        logic       exp_ovr;
        int         exp_rise;
    } vec_t;

    vec_t vecs [3];

    always #5 clk = ~clk;

    uart_rx_frame #(
        .CLKS_PER_BIT (CPB),
        .NUM_BYTES    (NB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .clear         (clear),
        .rx_ack        (rx_ack),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .framing_error (framing_error),
        .overrun_error (overrun_error)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [FW-1:0] pack_frame(input logic [7:0] base, input logic [7:0] step);
        logic [FW-1:0] v;
        logic [7:0]    b;
        v = '0;
        b = base;
        for (int i = 0; i < NB; i++) begin
            v[FW-8-8*i +: 8] = b;
            b = b + step;
        end
        return v;
    endfunction

    task automatic chk_vec(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        cycles(1);
        rx_ack = 1'b0;
    endtask

    // ack_at (1..CPB) raises rx_ack for one cycle during the stop bit; 0 means no ack.
    task automatic send_byte(input logic [7:0] d, input logic stop, input int ack_at);
        logic valid_before;
        serial_in = 1'b0;
        cycles(CPB);
        for (int b = 7; b >= 0; b--) begin
            serial_in = d[b];
            cycles(CPB);
        end
        serial_in    = stop;
        valid_before = rx_valid;
        rise_at      = 0;
        for (int i = 1; i <= CPB; i++) begin
            @(posedge clk);
            #1;
            rx_ack = (i == ack_at);
            if (rise_at == 0 && !valid_before && rx_valid) rise_at = i;
        end
        rx_ack    = 1'b0;
        serial_in = 1'b1;
        cycles(2);
    endtask

    task automatic send_frame(input logic [7:0] base, input logic [7:0] step, input int ack_at);
        logic [7:0] b;
        b = base;
        for (int i = 0; i < NB; i++) begin
            send_byte(b, 1'b1, (i == NB - 1) ? ack_at : 0);
            b = b + step;
        end
        $display("frame base=%h step=%h valid=%0b ovr=%0b ferr=%0b",
                 base, step, rx_valid, overrun_error, framing_error);
    endtask

    initial begin
        logic [FW-1:0] exp_frame;

        vecs[0] = '{base: 8'h00, step: 8'h01, ack_before: 1'b0, exp_valid: 1'b1, exp_ovr: 1'b0, exp_rise: RISE_EXP};
        vecs[1] = '{base: 8'h80, step: 8'h03, ack_before: 1'b1, exp_valid: 1'b1, exp_ovr: 1'b0, exp_rise: RISE_EXP};
        vecs[2] = '{base: 8'h5A, step: 8'h11, ack_before: 1'b1, exp_valid: 1'b1, exp_ovr: 1'b0, exp_rise: RISE_EXP};

        rst       = 1'b1;
        serial_in = 1'b1;
        clear     = 1'b0;
        rx_ack    = 1'b0;
        cycles(3);
        rst = 1'b0;
        cycles(3);

        chk_vec("reset_rx_data", rx_data, '0);
        chk_bit("reset_rx_valid", rx_valid, 1'b0);
        chk_bit("reset_framing", framing_error, 1'b0);
        chk_bit("reset_overrun", overrun_error, 1'b0);
        ack_pulse();
        chk_bit("ack_while_idle_ignored", rx_valid, 1'b0);

        for (int v = 0; v < 3; v++) begin
            if (vecs[v].ack_before) ack_pulse();
            send_frame(vecs[v].base, vecs[v].step, 0);
            chk_vec($sformatf("vec%0d_data", v), rx_data, pack_frame(vecs[v].base, vecs[v].step));
            chk_bit($sformatf("vec%0d_valid", v), rx_valid, vecs[v].exp_valid);
            chk_bit($sformatf("vec%0d_overrun", v), overrun_error, vecs[v].exp_ovr);
            chk_bit($sformatf("vec%0d_framing", v), framing_error, 1'b0);
            chk_int($sformatf("vec%0d_valid_rise", v), rise_at, vecs[v].exp_rise);
        end

        // Completion coincident with ack: frame replaces data, no overrun.
        send_frame(8'h10, 8'h02, CPB / 2 + 2);
        chk_vec("ack_coincident_data", rx_data, pack_frame(8'h10, 8'h02));
        chk_bit("ack_coincident_valid", rx_valid, 1'b1);
        chk_bit("ack_coincident_overrun", overrun_error, 1'b0);
        ack_pulse();
        chk_bit("ack_clears_valid", rx_valid, 1'b0);

        // Short low glitch must be rejected as a false start.
        serial_in = 1'b0;
        cycles(4);
        serial_in = 1'b1;
        cycles(3 * CPB);
        chk_bit("glitch_no_valid", rx_valid, 1'b0);
        send_frame(8'hA5, 8'h01, 0);
        chk_vec("glitch_then_frame_data", rx_data, pack_frame(8'hA5, 8'h01));
        chk_int("glitch_then_frame_rise", rise_at, RISE_EXP);

        // Second frame with no ack in between.
        send_frame(8'hC3, 8'h07, 0);
        chk_vec("overrun_data", rx_data, pack_frame(8'hC3, 8'h07));
        chk_bit("overrun_valid", rx_valid, 1'b1);
        chk_bit("overrun_flag", overrun_error, 1'b1);

        // Clear drops a 10-byte partial frame.
        ack_pulse();
        for (int i = 0; i < 10; i++) send_byte(8'(8'h20 + i), 1'b1, 0);
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        chk_bit("clear_keeps_overrun", overrun_error, 1'b1);
        send_frame(8'hFF, 8'h00, 0);
        chk_vec("clear_then_ones_data", rx_data, {FW{1'b1}});
        chk_bit("clear_then_ones_valid", rx_valid, 1'b1);
        chk_bit("overrun_sticky", overrun_error, 1'b1);

        // Reset during data bit 3 of byte 5.
        for (int i = 0; i < 5; i++) send_byte(8'(8'h30 + i), 1'b1, 0);
        serial_in = 1'b0;
        cycles(CPB);
        serial_in = 1'b1; cycles(CPB);
        serial_in = 1'b0; cycles(CPB);
        serial_in = 1'b1; cycles(CPB);
        serial_in = 1'b0;
        cycles(4);
        #2;
        rst       = 1'b1;
        serial_in = 1'b1;
        #1;
        chk_vec("midreset_rx_data", rx_data, '0);
        chk_bit("midreset_valid", rx_valid, 1'b0);
        chk_bit("midreset_overrun", overrun_error, 1'b0);
        chk_bit("midreset_framing", framing_error, 1'b0);
        cycles(2);
        rst = 1'b0;
        cycles(3 * CPB);
        send_frame(8'h61, 8'h05, 0);
        chk_vec("after_reset_data", rx_data, pack_frame(8'h61, 8'h05));
        chk_bit("after_reset_valid", rx_valid, 1'b1);
        chk_bit("after_reset_overrun", overrun_error, 1'b0);
        chk_int("after_reset_rise", rise_at, RISE_EXP);

        // Bad stop bit on 0x3C followed by a good frame.
        ack_pulse();
        send_byte(8'h3C, 1'b0, 0);
`ifdef UART_RX_FRAMING_CHECK_EN
        chk_bit("bad_stop_framing", framing_error, 1'b1);
`else
        chk_bit("bad_stop_framing", framing_error, 1'b0);
`endif
        chk_bit("bad_stop_no_valid", rx_valid, 1'b0);
        send_frame(8'h40, 8'h01, 0);
`ifdef UART_RX_FRAMING_CHECK_EN
        exp_frame = pack_frame(8'h40, 8'h01);
        chk_bit("framing_sticky", framing_error, 1'b1);
`else
        exp_frame = {8'h3C, pack_frame(8'h40, 8'h01) >> 8} ;
        exp_frame = {8'h3C, exp_frame[FW-9:0]};
        chk_bit("framing_tied_low", framing_error, 1'b0);
`endif
        chk_vec("after_bad_stop_data", rx_data, exp_frame);
        chk_bit("after_bad_stop_valid", rx_valid, 1'b1);
        chk_bit("after_bad_stop_overrun", overrun_error, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
